// File: rtl/div.sv
// Iterative 32-bit divider: one restoring step per cycle, signed or unsigned,
// result presented as {remainder, quotient} and held while start_i stays high.
module div (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  typedef enum logic [1:0] {
    ST_FREE   = 2'd0,
    ST_BYZERO = 2'd1,
    ST_ON     = 2'd2,
    ST_END    = 2'd3
  } state_t;

  // Magnitude of an operand; only negative values in signed mode are negated.
  function automatic logic [31:0] f_abs(input logic sgn, input logic [31:0] x);
    logic [31:0] v;
    if (sgn && x[31]) begin
      v = (~x) + 32'd1;
    end else begin
      v = x;
    end
    return v;
  endfunction

  state_t      r_state;
  state_t      w_state_nxt;
  logic [64:0] r_work;
  logic [64:0] w_work_nxt;
  logic [5:0]  r_cnt;
  logic [5:0]  w_cnt_nxt;
  logic [31:0] r_divisor;
  logic [31:0] w_divisor_nxt;
  logic [63:0] r_result;
  logic [63:0] w_result_nxt;
  logic        r_ready;
  logic        w_ready_nxt;

  logic [32:0] w_trial;
  logic        w_neg_quot;
  logic        w_neg_rem;
  logic [31:0] w_quot_fix;
  logic [31:0] w_rem_fix;

  // Trial subtraction of the divisor from the shifted partial remainder.
  assign w_trial = {1'b0, r_work[63:32]} - {1'b0, r_divisor};

  // Sign correction uses the live operands, which stay stable during the divide.
  assign w_neg_quot = signed_div_i && (opdata1_i[31] ^ opdata2_i[31]);
  assign w_neg_rem  = signed_div_i && opdata1_i[31];
  assign w_quot_fix = w_neg_quot ? ((~r_work[31:0]) + 32'd1) : r_work[31:0];
  assign w_rem_fix  = w_neg_rem  ? ((~r_work[64:33]) + 32'd1) : r_work[64:33];

  // Next-state and datapath decode; outputs are zero everywhere except END.
  always_comb begin
    w_state_nxt   = r_state;
    w_work_nxt    = r_work;
    w_cnt_nxt     = r_cnt;
    w_divisor_nxt = r_divisor;
    w_result_nxt  = 64'h0;
    w_ready_nxt   = 1'b0;
    case (r_state)
      ST_FREE: begin
        if (start_i && !annul_i) begin
          if (opdata2_i == 32'h0) begin
            w_state_nxt = ST_BYZERO;
          end else begin
            w_state_nxt   = ST_ON;
            w_cnt_nxt     = 6'd0;
            w_divisor_nxt = f_abs(signed_div_i, opdata2_i);
            w_work_nxt    = {32'h0, f_abs(signed_div_i, opdata1_i), 1'b0};
          end
        end else begin
          w_state_nxt = ST_FREE;
        end
      end
      ST_BYZERO: begin
        if (annul_i) begin
          w_state_nxt = ST_FREE;
        end else begin
          w_work_nxt  = 65'h0;
          w_state_nxt = ST_END;
        end
      end
      ST_ON: begin
        if (annul_i) begin
          w_state_nxt = ST_FREE;
        end else if (r_cnt != 6'd32) begin
          if (w_trial[32]) begin
            w_work_nxt = {r_work[63:0], 1'b0};
          end else begin
            w_work_nxt = {w_trial[31:0], r_work[31:0], 1'b1};
          end
          w_cnt_nxt = r_cnt + 6'd1;
        end else begin
          w_work_nxt  = {w_rem_fix, r_work[32], w_quot_fix};
          w_state_nxt = ST_END;
        end
      end
      ST_END: begin
        if (start_i) begin
          w_result_nxt = {r_work[64:33], r_work[31:0]};
          w_ready_nxt  = 1'b1;
        end else begin
          w_state_nxt  = ST_FREE;
          w_result_nxt = 64'h0;
          w_ready_nxt  = 1'b0;
        end
      end
      default: begin
        w_state_nxt = ST_FREE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= ST_FREE;
      r_work    <= 65'h0;
      r_cnt     <= 6'd0;
      r_divisor <= 32'h0;
      r_result  <= 64'h0;
      r_ready   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_work    <= w_work_nxt;
      r_cnt     <= w_cnt_nxt;
      r_divisor <= w_divisor_nxt;
      r_result  <= w_result_nxt;
      r_ready   <= w_ready_nxt;
    end
  end

  assign result_o = r_result;
  assign ready_o  = r_ready;

endmodule

// File: tb/tb_div.sv
// Scoreboard bench for div: the driver queues expected results and ready
// cycles, a negedge monitor checks every rising ready_o against the queue.
module tb_div;

  logic        clk;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit mon_en   = 1'b0;

  logic [63:0] exp_q[$];
  int          cyc_q[$];

  div dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: idle outputs are zero, held results stay stable, each new
  // result matches the oldest queued expectation and its ready cycle.
  logic        prev_ready = 1'b0;
  logic [63:0] prev_res   = 64'h0;
  always @(negedge clk) begin
    if (mon_en) begin
      if (!ready_o) begin
        checks++;
        if (result_o !== 64'h0) begin
          failures++;
          $display("FAIL idle_zero cyc=%0d result=%h required=0", cyc, result_o);
        end
      end else if (prev_ready) begin
        checks++;
        if (result_o !== prev_res) begin
          failures++;
          $display("FAIL hold cyc=%0d result=%h required=%h", cyc, result_o, prev_res);
        end
      end else begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_ready cyc=%0d result=%h required=no ready", cyc, result_o);
        end else begin
          logic [63:0] e;
          int          ec;
          e  = exp_q.pop_front();
          ec = cyc_q.pop_front();
          if (result_o !== e) begin
            failures++;
            $display("FAIL result cyc=%0d result=%h required=%h", cyc, result_o, e);
          end
          checks++;
          if (cyc != ec) begin
            failures++;
            $display("FAIL latency ready_cycle=%0d required=%0d", cyc, ec);
          end
        end
      end
    end
    prev_ready = ready_o;
    prev_res   = result_o;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_op(input logic [63:0] e, input int lat);
    exp_q.push_back(e);
    cyc_q.push_back(cyc + 1 + lat);
  endtask

  task automatic launch(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
  endtask

  // Wait for ready, hold start for extra cycles, then drop it and expect FREE.
  task automatic complete(input int hold);
    int n;
    n = 0;
    while (!ready_o && n < 60) begin
      step();
      n++;
    end
    if (!ready_o) begin
      checks++;
      failures++;
      $display("FAIL timeout ready=%0b required=1", ready_o);
    end
    repeat (hold) step();
    start_i = 1'b0;
    step();
    checks++;
    if (ready_o !== 1'b0 || result_o !== 64'h0) begin
      failures++;
      $display("FAIL drop ready=%0b result=%h required=0/0", ready_o, result_o);
    end
  endtask

  task automatic run(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                     input logic [63:0] e, input int hold);
    launch(sgn, a, b);
    expect_op(e, (b == 32'h0) ? 2 : 34);
    complete(hold);
  endtask

  initial begin
    rst = 1'b0; start_i = 1'b0; annul_i = 1'b0;
    signed_div_i = 1'b0; opdata1_i = 32'h0; opdata2_i = 32'h0;
    repeat (3) step();
    checks++;
    if (ready_o !== 1'b0 || result_o !== 64'h0) begin
      failures++;
      $display("FAIL reset ready=%0b result=%h required=0/0", ready_o, result_o);
    end
    rst = 1'b1;
    mon_en = 1'b1;
    step();

    run(1'b0, 32'd100,       32'd7,       64'h00000002_0000000E, 0);
    run(1'b1, 32'hFFFFFFF9,  32'h2,       64'hFFFFFFFF_FFFFFFFD, 0);
    run(1'b1, 32'd7,         32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 0);
    run(1'b0, 32'd5,         32'd0,       64'h0, 0);
    run(1'b1, 32'hFFFFFF9C,  32'hFFFFFFF9, 64'hFFFFFFFE_0000000E, 1);
    run(1'b0, 32'hFFFFFFF9,  32'h2,       64'h00000001_7FFFFFFC, 0);
    run(1'b0, 32'hFFFFFFFF,  32'hFFFFFFFF, 64'h00000000_00000001, 0);
    run(1'b0, 32'd3,         32'd5,       64'h00000003_00000000, 0);
    run(1'b1, 32'h80000000,  32'h0,       64'h0, 2);

    // Annul at iteration 10; start+annul in FREE is ignored for one edge.
    launch(1'b0, 32'd1000, 32'd3);
    step();
    repeat (10) step();
    annul_i = 1'b1;
    step();
    step();
    checks++;
    if (ready_o !== 1'b0 || result_o !== 64'h0) begin
      failures++;
      $display("FAIL annul ready=%0b result=%h required=0/0", ready_o, result_o);
    end
    opdata1_i = 32'hFFFFFFFF;
    opdata2_i = 32'h10;
    annul_i   = 1'b0;
    expect_op(64'h0000000F_0FFFFFFF, 34);
    complete(0);

    // Reset at iteration 20 with start held; re-accepted after release.
    launch(1'b0, 32'd50, 32'd3);
    step();
    repeat (20) step();
    rst = 1'b0;
    step();
    checks++;
    if (ready_o !== 1'b0 || result_o !== 64'h0) begin
      failures++;
      $display("FAIL midreset ready=%0b result=%h required=0/0", ready_o, result_o);
    end
    rst = 1'b1;
    expect_op(64'h00000002_00000010, 34);
    complete(0);

    run(1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 5);

    repeat (40) step();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL pending outstanding=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
